// File: rtl/led_time_display.sv
// -----------------------------------------------------------------------------
// led_time_display
//
// Drives the on-board LED bar from the round timer. Shows the remaining
// seconds as a thermometer bar, blinks the bar while time is low, and when the
// tracker reports a timeout runs a fixed number of all-LED flashes before
// holding a done flag for the round controller.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous, active-high reset
//   enable     in   round active; low forces IDLE
//   timeValue  in   remaining seconds (4 bits) from the time tracker
//   timeout    in   level, 1 = time expired
//   leds       out  LED bar drive, 1 = lit (NUM_LEDS bits)
//   warn       out  high while in WARN
//   tick       out  one-cycle pulse per observed one-second decrement
//   flashDone  out  high while in DONE
//
// All outputs are registered: an input change appears one cycle later.
// -----------------------------------------------------------------------------
module led_time_display #(
   parameter int unsigned NUM_LEDS    = 10,
   parameter int unsigned BLINK_DIV   = 25000000,
   parameter int unsigned WARN_LEVEL  = 3,
   parameter int unsigned FLASH_COUNT = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [3:0]          timeValue,
   input  logic                timeout,
   output logic [NUM_LEDS-1:0] leds,
   output logic                warn,
   output logic                tick,
   output logic                flashDone
);

   localparam int unsigned PW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam int unsigned FW = (FLASH_COUNT > 1) ? $clog2(FLASH_COUNT + 1) : 1;

   localparam logic [PW-1:0] PRE_MAX  = PW'(BLINK_DIV - 1);
   localparam logic [FW-1:0] FLASH_N  = FW'(FLASH_COUNT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_BAR,
      S_WARN,
      S_FLASH,
      S_DONE
   } state_t;

   state_t                state_q, state_d;
   logic [PW-1:0]         pre_q, pre_d;
   logic                  phase_q, phase_d;
   logic [FW-1:0]         cnt_q, cnt_d;
   logic [3:0]            prev_q, prev_d;
   logic [NUM_LEDS-1:0]   leds_q, leds_d;
   logic                  warn_q, warn_d;
   logic                  tick_q, tick_d;
   logic                  done_q, done_d;

   int unsigned           tv_u;
   int unsigned           v_u;
   logic [NUM_LEDS-1:0]   bar_v;
   logic                  low_time;
   logic                  wrap;
   logic                  flash_end;
   logic                  entering;

   // Clamp the incoming value and build the thermometer pattern.
   always_comb begin
      tv_u  = 32'(timeValue);
      v_u   = (tv_u > NUM_LEDS) ? NUM_LEDS : tv_u;
      bar_v = '0;
      for (int unsigned i = 0; i < NUM_LEDS; i++) begin
         bar_v[i] = (i < v_u);
      end
      low_time = (v_u >= 1) && (v_u <= WARN_LEVEL);
   end

   // Next-state, timebase and output decode.
   always_comb begin
      wrap      = (pre_q == PRE_MAX);
      // The last off-toggle of the flash sequence leaves FLASH directly.
      flash_end = (state_q == S_FLASH) && wrap && phase_q &&
                  ((cnt_q + FW'(1)) == FLASH_N);

      state_d = state_q;
      if (!enable) begin
         state_d = S_IDLE;
      end else if (timeout && (state_q == S_IDLE || state_q == S_BAR ||
                               state_q == S_WARN)) begin
         state_d = S_FLASH;
      end else begin
         unique case (state_q)
            S_IDLE, S_BAR, S_WARN: state_d = low_time ? S_WARN : S_BAR;
            S_FLASH:               state_d = flash_end ? S_DONE : S_FLASH;
            S_DONE:                state_d = S_DONE;
            default:               state_d = S_IDLE;
         endcase
      end

      entering = ((state_d == S_WARN)  && (state_q != S_WARN)) ||
                 ((state_d == S_FLASH) && (state_q != S_FLASH));

      pre_d   = pre_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      if (state_d == S_IDLE) begin
         pre_d   = '0;
         phase_d = 1'b0;
         cnt_d   = '0;
      end else if (state_d == S_DONE) begin
         pre_d   = '0;
         phase_d = 1'b0;
      end else if (entering) begin
         // Restart so the first half-period after entry is lit.
         pre_d   = '0;
         phase_d = 1'b1;
         cnt_d   = '0;
      end else if (wrap) begin
         pre_d   = '0;
         phase_d = ~phase_q;
         if ((state_q == S_FLASH) && phase_q) begin
            cnt_d = cnt_q + FW'(1);
         end
      end else begin
         pre_d = pre_q + PW'(1);
      end

      prev_d = timeValue;

      leds_d = '0;
      warn_d = 1'b0;
      done_d = 1'b0;
      unique case (state_d)
         S_BAR:   leds_d = bar_v;
         S_WARN: begin
            warn_d = 1'b1;
            leds_d = phase_d ? bar_v : '0;
         end
         S_FLASH: leds_d = phase_d ? '1 : '0;
         S_DONE:  done_d = 1'b1;
         default: leds_d = '0;
      endcase

      // Only an exact one-second step down counts; prev 0 cannot step down.
      tick_d = ((state_d == S_BAR) || (state_d == S_WARN)) &&
               (prev_q != 4'd0) && (timeValue == (prev_q - 4'd1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
         phase_q <= 1'b0;
         cnt_q   <= '0;
         prev_q  <= '0;
         leds_q  <= '0;
         warn_q  <= 1'b0;
         tick_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         phase_q <= phase_d;
         cnt_q   <= cnt_d;
         prev_q  <= prev_d;
         leds_q  <= leds_d;
         warn_q  <= warn_d;
         tick_q  <= tick_d;
         done_q  <= done_d;
      end
   end

   assign leds      = leds_q;
   assign warn      = warn_q;
   assign tick      = tick_q;
   assign flashDone = done_q;

endmodule

// File: tb/tb_led_time_display.sv
module tb_led_time_display;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [3:0] timeValue;
   logic       timeout;
   logic [9:0] leds;
   logic       warn;
   logic       tick;
   logic       flashDone;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   led_time_display #(
      .NUM_LEDS   (10),
      .BLINK_DIV  (4),
      .WARN_LEVEL (3),
      .FLASH_COUNT(3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .enable    (enable),
      .timeValue (timeValue),
      .timeout   (timeout),
      .leds      (leds),
      .warn      (warn),
      .tick      (tick),
      .flashDone (flashDone)
   );

   typedef struct {
      logic [9:0] leds;
      logic       warn;
      logic       tick;
      logic       done;
      string      name;
   } exp_t;

   typedef struct {
      logic       en;
      logic [3:0] tv;
      logic       to;
      logic [9:0] leds;
      logic       warn;
      logic       tick;
      logic       done;
      string      name;
   } vec_t;

   exp_t sb[$];
   vec_t vec[18];

   task automatic compare(input string name, input logic [9:0] el, input logic ew,
                          input logic et, input logic ed);
      checks++;
      if (leds !== el || warn !== ew || tick !== et || flashDone !== ed) begin
         errors++;
         $display("FAIL %s: got leds=%h warn=%b tick=%b done=%b, expected leds=%h warn=%b tick=%b done=%b",
                  name, leds, warn, tick, flashDone, el, ew, et, ed);
      end
   endtask

   // Drive one cycle of inputs, queue the expectation, then check it after the edge.
   task automatic step(input logic en, input logic [3:0] tv, input logic to,
                       input logic [9:0] el, input logic ew, input logic et,
                       input logic ed, input string name);
      exp_t e;
      enable    = en;
      timeValue = tv;
      timeout   = to;
      e.leds = el; e.warn = ew; e.tick = et; e.done = ed; e.name = name;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      compare(e.name, e.leds, e.warn, e.tick, e.done);
   endtask

   initial begin
      //            en  tv     to   leds     warn  tick  done  name
      vec[0]  = '{1'b1, 4'd7,  1'b0, 10'h07F, 1'b0, 1'b0, 1'b0, "bar7"};
      vec[1]  = '{1'b1, 4'd12, 1'b0, 10'h3FF, 1'b0, 1'b0, 1'b0, "clamp12"};
      vec[2]  = '{1'b1, 4'd5,  1'b0, 10'h01F, 1'b0, 1'b0, 1'b0, "bar5"};
      vec[3]  = '{1'b1, 4'd4,  1'b0, 10'h00F, 1'b0, 1'b1, 1'b0, "tick5to4"};
      vec[4]  = '{1'b1, 4'd4,  1'b0, 10'h00F, 1'b0, 1'b0, 1'b0, "tick_one_cycle"};
      vec[5]  = '{1'b1, 4'd9,  1'b0, 10'h1FF, 1'b0, 1'b0, 1'b0, "reload_no_tick"};
      vec[6]  = '{1'b1, 4'd8,  1'b0, 10'h0FF, 1'b0, 1'b1, 1'b0, "tick9to8"};
      vec[7]  = '{1'b1, 4'd0,  1'b0, 10'h000, 1'b0, 1'b0, 1'b0, "bar_zero"};
      vec[8]  = '{1'b1, 4'd3,  1'b0, 10'h007, 1'b1, 1'b0, 1'b0, "warn_entry"};
      vec[9]  = '{1'b1, 4'd3,  1'b0, 10'h007, 1'b1, 1'b0, 1'b0, "warn_lit1"};
      vec[10] = '{1'b1, 4'd2,  1'b0, 10'h003, 1'b1, 1'b1, 1'b0, "warn_lit2_v2"};
      vec[11] = '{1'b1, 4'd2,  1'b0, 10'h003, 1'b1, 1'b0, 1'b0, "warn_lit3"};
      vec[12] = '{1'b1, 4'd2,  1'b0, 10'h000, 1'b1, 1'b0, 1'b0, "warn_dark0"};
      vec[13] = '{1'b1, 4'd2,  1'b0, 10'h000, 1'b1, 1'b0, 1'b0, "warn_dark1"};
      vec[14] = '{1'b1, 4'd2,  1'b0, 10'h000, 1'b1, 1'b0, 1'b0, "warn_dark2"};
      vec[15] = '{1'b1, 4'd2,  1'b0, 10'h000, 1'b1, 1'b0, 1'b0, "warn_dark3"};
      vec[16] = '{1'b1, 4'd2,  1'b0, 10'h003, 1'b1, 1'b0, 1'b0, "warn_relit"};
      vec[17] = '{1'b1, 4'd1,  1'b0, 10'h001, 1'b1, 1'b1, 1'b0, "warn_tick2to1"};

      rst = 1'b1; enable = 1'b0; timeValue = 4'd0; timeout = 1'b0;
      #12;
      compare("reset_state", 10'h000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;

      step(1'b0, 4'd0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, "idle_after_reset");

      for (int i = 0; i < 18; i++) begin
         step(vec[i].en, vec[i].tv, vec[i].to, vec[i].leds, vec[i].warn,
              vec[i].tick, vec[i].done, vec[i].name);
      end

      // Timeout flash: three 4-cycle lit pulses; timeout released mid-sequence.
      for (int k = 0; k < 20; k++) begin
         logic       to_k;
         logic [3:0] tv_k;
         logic [9:0] el;
         to_k = (k < 6);
         tv_k = (k < 6) ? 4'd1 : 4'd0;
         el   = (((k / 4) % 2) == 0) ? 10'h3FF : 10'h000;
         step(1'b1, tv_k, to_k, el, 1'b0, 1'b0, 1'b0, $sformatf("flash_k%0d", k));
      end
      step(1'b1, 4'd0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, "flash_done");
      step(1'b1, 4'd9, 1'b1, 10'h000, 1'b0, 1'b0, 1'b1, "done_hold_to");
      step(1'b1, 4'd8, 1'b0, 10'h000, 1'b0, 1'b0, 1'b1, "done_hold_tv");
      step(1'b0, 4'd10, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, "done_enable_drop");
      step(1'b1, 4'd10, 1'b0, 10'h3FF, 1'b0, 1'b0, 1'b0, "reenable_10");

      // Enable drop in the middle of a flash.
      step(1'b1, 4'd10, 1'b1, 10'h3FF, 1'b0, 1'b0, 1'b0, "flash2_entry");
      step(1'b1, 4'd10, 1'b0, 10'h3FF, 1'b0, 1'b0, 1'b0, "flash2_lit");
      step(1'b0, 4'd10, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, "flash_enable_drop");

      // Asynchronous reset while in WARN with tick high.
      step(1'b1, 4'd4, 1'b0, 10'h00F, 1'b0, 1'b0, 1'b0, "pre_warn_bar4");
      step(1'b1, 4'd3, 1'b0, 10'h007, 1'b1, 1'b1, 1'b0, "warn_with_tick");
      #2;
      rst = 1'b1;
      #1;
      compare("async_reset_immediate", 10'h000, 1'b0, 1'b0, 1'b0);
      #1;
      rst = 1'b0;
      step(1'b0, 4'd5, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, "post_reset_idle0");
      step(1'b0, 4'd5, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, "post_reset_idle1");
      step(1'b1, 4'd5, 1'b0, 10'h01F, 1'b0, 1'b0, 1'b0, "post_reset_enable");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      errors++;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

endmodule
